// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce and hex/decimal digit entry into a 32-bit value.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_entry #(
    parameter int SCAN_DIV = 150000,
    parameter int DEBOUNCE = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mod,
    input  logic        clr,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [31:0] data,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        ovf
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESSED = 1'b1;

    logic [3:0]    row_m, row_s;
    logic [DW-1:0] div;
    logic [1:0]    col_idx;
    logic          scan_hit;
    logic [3:0]    scan_code;
    logic          prev_hit;
    logic [3:0]    prev_code;
    logic [CW-1:0] deb_cnt;
    logic [0:0]    state;
    logic [3:0]    count;

    logic       samp_hit, last, frame_tick, frame_hit, same, stable, press_now;
    logic [1:0] samp_row;
    logic [3:0] cand_code, frame_code, in_code;

    always_comb begin
        samp_row = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (!row_s[3-i]) samp_row = 2'(3 - i);
    end

    // Codes are row-major, so the running frame minimum is the lowest pressed code overall.
    assign samp_hit   = ~&row_s;
    assign cand_code  = {samp_row, col_idx};
    assign frame_hit  = scan_hit | samp_hit;
    assign frame_code = !frame_hit ? '0 :
                        (scan_hit && (!samp_hit || scan_code < cand_code)) ? scan_code : cand_code;
    assign last       = (div == DIV_LAST);
    assign frame_tick = last && (col_idx == 2'd3);
    assign same       = (frame_hit == prev_hit) && (frame_code == prev_code);
    assign stable     = (deb_cnt == DEB_MAX);
    assign press_now  = (state == IDLE) && stable && prev_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m     <= '1;
            row_s     <= '1;
            div       <= '0;
            col_idx   <= '0;
            col       <= 4'b1110;
            scan_hit  <= 1'b0;
            scan_code <= '0;
            prev_hit  <= 1'b0;
            prev_code <= '0;
            deb_cnt   <= '0;
        end else begin
            row_m <= row;
            row_s <= row_m;
            if (last) begin
                div     <= '0;
                col_idx <= col_idx + 2'd1;
                col     <= ~(4'b0001 << (col_idx + 2'd1));
                if (frame_tick) begin
                    scan_hit  <= 1'b0;
                    scan_code <= '0;
                    prev_hit  <= frame_hit;
                    prev_code <= frame_code;
                    if (!same)
                        deb_cnt <= CW'(1);
                    else if (deb_cnt != DEB_MAX)
                        deb_cnt <= deb_cnt + CW'(1);
                end else begin
                    scan_hit  <= frame_hit;
                    scan_code <= frame_code;
                end
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            key_code <= '0;
        end else begin
            if (press_now) begin
                state    <= PRESSED;
                key_code <= prev_code;
            end else if (state == PRESSED && stable && !prev_hit) begin
                state <= IDLE;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
    logic [RW-1:0] rep_cnt;
    logic          rep_armed, rep_fire;

    // Counter held at zero outside PRESSED, so it starts fresh on every new press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_fire  <= 1'b0;
        end else if (state != PRESSED) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_fire  <= 1'b0;
        end else begin
            rep_fire <= 1'b0;
            if (frame_tick) begin
                if (!rep_armed && rep_cnt == RW'(REPEAT_DELAY - 1)) begin
                    rep_fire  <= 1'b1;
                    rep_armed <= 1'b1;
                    rep_cnt   <= '0;
                end else if (rep_armed && rep_cnt == RW'(REPEAT_RATE - 1)) begin
                    rep_fire <= 1'b1;
                    rep_cnt  <= '0;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end
        end
    end

    assign key_valid = press_now | (rep_fire && state == PRESSED && stable && prev_hit);
`else
    assign key_valid = press_now;
`endif

    assign in_code = press_now ? prev_code : key_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            data  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (key_valid && (mod || in_code <= 4'd9)) begin
            if (count == 4'd8) begin
                ovf <= 1'b1;
            end else begin
                count <= count + 4'd1;
                if (mod)
                    data <= {data[27:0], in_code};
                else
                    data <= {data[28:0], 3'b000} + {data[30:0], 1'b0} + {28'b0, in_code};
            end
        end
    end
endmodule
